// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem requests, IF/ID register with a
// one-entry skid buffer for hazard stalls and branch redirect/flush.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    fetch_stage_if.master        imem,
    output logic [31:0]          ifid_instr,
    output logic [31:0]          ifid_pc4,
    output logic                 ifid_valid,
    output logic [5:0]           opcode
);

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic        xfer;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    assign imem.imem_req  = (state_q == FETCH) && !reset;
    assign imem.imem_addr = pc_q;
    assign xfer           = imem.imem_req && imem.imem_ready;
    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = branch_target & 32'hFFFF_FFFC;

    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign opcode     = ifid_instr_q[31:26];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        unique case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    // Redirect wins over any same-cycle transfer, which is discarded.
                    pc_d         = target_aligned;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                end else if (xfer) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = HELD;
                    end else begin
                        ifid_instr_d = imem.imem_rdata;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                end
            end
            HELD: begin
                if (branch_taken) begin
                    pc_d         = target_aligned;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                    state_d      = FETCH;
                end else if (!stall) begin
                    ifid_instr_d = skid_instr_q;
                    ifid_pc4_d   = skid_pc4_q;
                    ifid_valid_d = 1'b1;
                    state_d      = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= PC_RESET;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

endmodule
